flappy_game_ctrl: RTL and testbench
===================================

# flappy_game_ctrl

Top-level game sequencer for the Flappy Bird FPGA design. Owns the game state machine (idle, play, game-over hold), gates the `start` enable of the collision/scoring block, and turns that block's `over`/`point` outputs into state changes and a saturating BCD score. It also generates the frame tick that paces bird and wall motion, and produces a one-cycle flap pulse for the bird physics.

## Interface

Parameters:
- `TICK_DIV`, default 25_000_000: clk cycles per frame tick; legal range ≥ 2.
- `HOLD_TICKS`, default 50: frame ticks spent in OVER before a flap is accepted; legal range ≥ 1.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `flap_btn` in 1: flap button level, already synchronised to `clk`.
- `over` in 1: collision flag from the collision/scoring block.
- `point` in 1: one-cycle wall-cleared pulse from the collision/scoring block.
- `start` out 1: enable to the collision/scoring block and the playfield; high only in PLAY.
- `frame_tick` out 1: one-cycle pulse every `TICK_DIV` clk cycles.
- `flap_pulse` out 1: one-cycle pulse per accepted flap in PLAY.
- `state` out 2: current state; IDLE=0, PLAY=1, OVER=2; code 3 is never used.
- `score` out 8: two BCD digits, `[7:4]` tens and `[3:0]` units.
- `hiscore` out 8: two BCD digits; the best score since reset.

## Operation

- **Flap edge detect:** `flap_q` samples `flap_btn` every cycle. `flap_edge = flap_btn & ~flap_q`.
- **Tick counter:**
  - Counts 0..`TICK_DIV`-1 in every state and wraps.
  - `frame_tick` is registered and is high in the cycle after the counter reaches `TICK_DIV`-1.
- **FSM:**
  - IDLE: on `flap_edge`, go to PLAY and clear `score` to 0x00 in the same edge.
  - PLAY:
    - `flap_edge` gives a registered `flap_pulse` in the next cycle.
    - `point` increments `score` in BCD. Units wrap 9→0 with a carry into tens. The score saturates at 0x99.
    - `over` causes the transition to OVER. `over` has priority: if `over` and `point` are both high in the same cycle, the point is discarded.
  - OVER:
    - On entry, load the hold counter with `HOLD_TICKS`. Each `frame_tick` decrements it.
    - Once the counter is 0, `flap_edge` goes to IDLE.
    - Flap edges before expiry are ignored.
    - `score` holds its value through OVER and IDLE until the next game starts.
- **High score:** on the PLAY→OVER edge, if `score` > `hiscore` (compared as BCD, which equals unsigned compare), load `hiscore` with `score`.
- **Ignored inputs:**
  - `over` and `point` are ignored outside PLAY.
  - `flap_pulse` is never asserted outside PLAY. The flap that starts a game does not generate `flap_pulse`.

## Timing

- **All outputs are registered.**
- **Reset values:** `state`=IDLE, `start`=0, `frame_tick`=0, `flap_pulse`=0, `score`=0x00, `hiscore`=0x00, tick counter=0, hold counter=0, `flap_q`=0.
- **Reset mid-game:** aborts immediately. The next cycle is IDLE with all values above.
- **Start latency:** `flap_btn` rises in cycle N (with `flap_q`=0), so `state`=PLAY and `start`=1 from cycle N+1.
- **Over latency:** `over` high in cycle N, so `state`=OVER and `start`=0 from N+1. `hiscore` is updated at N+1.
- **Point latency:** `point` high in cycle N, so `score` is updated at N+1.
- **Flap held high:** produces exactly one edge. A new edge needs `flap_btn` low for at least one cycle.
- **Tick while hold is 0:** a `frame_tick` while the hold counter is 0 leaves it at 0 (no underflow).
- **OVER→IDLE:** `flap_edge` in the first cycle where hold=0 is accepted.

## Configuration

- `GAME_HISCORE_EN` defined: the high-score register and compare are built as described above.
- `GAME_HISCORE_EN` undefined: the register is not built and `hiscore` is tied to 0x00. All other behaviour is unchanged.

## Test plan

Run with `TICK_DIV`=4 and `HOLD_TICKS`=2 unless noted.

- **Reset/start:** assert `reset` for 2 cycles with `flap_btn`=1 → IDLE, all outputs 0. Then `flap_btn` 0→1 → `state`=1 and `start`=1 one cycle later, with `flap_pulse` staying 0.
- **Frame tick:** free-run 12 cycles → `frame_tick` pulses exactly 3 times, 4 cycles apart, in every state.
- **Scoring and saturation:**
  - In PLAY, 10 `point` pulses → `score`=0x10.
  - Preload to 0x99 via 99 pulses, then one more → stays 0x99.
- **Priority:** `point` and `over` high in the same cycle with `score`=0x05 → OVER, `score`=0x05, `hiscore`=0x05.
- **Hold window:**
  - In OVER, flap edges before 2 `frame_tick`s → stay OVER.
  - Flap edge after expiry → IDLE.
  - Next flap → PLAY with `score`=0x00 and `hiscore` retained.
  - A lower second game (0x03) leaves `hiscore`=0x05.
- **Mid-game reset:** `reset` while in PLAY with `score`=0x07 → next cycle IDLE, `score`=0x00, `hiscore`=0x00. Also run the bench with `GAME_HISCORE_EN` undefined → `hiscore` is 0x00 throughout.

Source files
------------

// File: rtl/flappy_game_ctrl.sv
// Flappy Bird game sequencer: FSM, frame tick, flap pulse, BCD score.
// Define GAME_HISCORE_EN to build the high-score register.
module flappy_game_ctrl #(
   parameter int TICK_DIV   = 25_000_000,
   parameter int HOLD_TICKS = 50
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       flap_btn,
   input  logic       over,
   input  logic       point,
   output logic       start,
   output logic       frame_tick,
   output logic       flap_pulse,
   output logic [1:0] state,
   output logic [7:0] score,
   output logic [7:0] hiscore
);

   localparam int TW = $clog2(TICK_DIV);
   localparam int HW = $clog2(HOLD_TICKS + 1);
   localparam logic [TW-1:0] TICK_MAX  = TW'(TICK_DIV - 1);
   localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_TICKS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_OVER = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          flap_q, flap_d;
   logic          frame_tick_q, frame_tick_d;
   logic          flap_pulse_q, flap_pulse_d;
   logic          start_q, start_d;
   logic [7:0]    score_q, score_d;
   logic [7:0]    score_inc;
   logic          flap_edge;

   assign flap_edge = flap_btn & ~flap_q;

   // BCD increment that sticks at 99
   always_comb begin
      score_inc = score_q;
      if (score_q != 8'h99) begin
         if (score_q[3:0] == 4'd9) begin
            score_inc = {score_q[7:4] + 4'd1, 4'd0};
         end else begin
            score_inc = {score_q[7:4], score_q[3:0] + 4'd1};
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      score_d      = score_q;
      hold_d       = hold_q;
      flap_d       = flap_btn;
      flap_pulse_d = 1'b0;
      frame_tick_d = (tick_q == TICK_MAX);
      tick_d       = (tick_q == TICK_MAX) ? '0 : tick_q + 1'b1;

      unique case (state_q)
         S_IDLE: begin
            if (flap_edge) begin
               state_d = S_PLAY;
               score_d = 8'h00;
            end
         end
         S_PLAY: begin
            if (over) begin
               state_d = S_OVER;
               hold_d  = HOLD_INIT;
            end else begin
               if (point) begin
                  score_d = score_inc;
               end
               flap_pulse_d = flap_edge;
            end
         end
         S_OVER: begin
            if (hold_q == '0) begin
               if (flap_edge) begin
                  state_d = S_IDLE;
               end
            end else if (frame_tick_q) begin
               hold_d = hold_q - 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      start_d = (state_d == S_PLAY);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         tick_q       <= '0;
         hold_q       <= '0;
         flap_q       <= 1'b0;
         frame_tick_q <= 1'b0;
         flap_pulse_q <= 1'b0;
         start_q      <= 1'b0;
         score_q      <= 8'h00;
      end else begin
         state_q      <= state_d;
         tick_q       <= tick_d;
         hold_q       <= hold_d;
         flap_q       <= flap_d;
         frame_tick_q <= frame_tick_d;
         flap_pulse_q <= flap_pulse_d;
         start_q      <= start_d;
         score_q      <= score_d;
      end
   end

`ifdef GAME_HISCORE_EN
   logic [7:0] hiscore_q, hiscore_d;

   always_comb begin
      hiscore_d = hiscore_q;
      if (state_q == S_PLAY && over && score_q > hiscore_q) begin
         hiscore_d = score_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hiscore_q <= 8'h00;
      end else begin
         hiscore_q <= hiscore_d;
      end
   end

   assign hiscore = hiscore_q;
`else
   assign hiscore = 8'h00;
`endif

   assign state      = state_q;
   assign start      = start_q;
   assign frame_tick = frame_tick_q;
   assign flap_pulse = flap_pulse_q;
   assign score      = score_q;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Bench for flappy_game_ctrl: vector table, corner sequences, random run
// against a decimal-score reference model.
module tb_flappy_game_ctrl;

   localparam int TICK_DIV   = 4;
   localparam int HOLD_TICKS = 2;
`ifdef GAME_HISCORE_EN
   localparam bit HI_EN = 1'b1;
`else
   localparam bit HI_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       flap_btn = 1'b0;
   logic       over = 1'b0;
   logic       point = 1'b0;
   logic       start;
   logic       frame_tick;
   logic       flap_pulse;
   logic [1:0] state;
   logic [7:0] score;
   logic [7:0] hiscore;

   int tests = 0;
   int fails = 0;

   flappy_game_ctrl #(
      .TICK_DIV   (TICK_DIV),
      .HOLD_TICKS (HOLD_TICKS)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .flap_btn   (flap_btn),
      .over       (over),
      .point      (point),
      .start      (start),
      .frame_tick (frame_tick),
      .flap_pulse (flap_pulse),
      .state      (state),
      .score      (score),
      .hiscore    (hiscore)
   );

   always #5 clk = ~clk;

   // reference model: score kept as a plain decimal number
   int m_state;
   int m_score;
   int m_hi;
   int m_seen;
   int m_cyc;
   bit m_prev;
   bit m_ft;
   bit m_fp;

   function automatic logic [7:0] bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   task automatic model_step(input bit r, input bit f,
                             input bit o, input bit p);
      bit edge_s;
      bit ft_n;
      bit fp_n;
      if (r) begin
         m_state = 0; m_score = 0; m_hi = 0; m_seen = 0;
         m_cyc = 0; m_prev = 0; m_ft = 0; m_fp = 0;
         return;
      end
      edge_s = f && !m_prev;
      ft_n = (m_cyc == TICK_DIV - 1);
      m_cyc = (m_cyc + 1) % TICK_DIV;
      fp_n = 0;
      case (m_state)
         0: if (edge_s) begin
               m_state = 1;
               m_score = 0;
            end
         1: if (o) begin
               if (HI_EN && m_score > m_hi) m_hi = m_score;
               m_state = 2;
               m_seen = 0;
            end else begin
               if (p && m_score < 99) m_score++;
               if (edge_s) fp_n = 1;
            end
         default: if (m_seen >= HOLD_TICKS) begin
               if (edge_s) m_state = 0;
            end else if (m_ft) begin
               m_seen++;
            end
      endcase
      m_ft = ft_n;
      m_fp = fp_n;
      m_prev = f;
   endtask

   task automatic chk(input string name, input logic [7:0] act,
                      input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic step(input bit r, input bit f,
                       input bit o, input bit p);
      reset = r; flap_btn = f; over = o; point = p;
      @(posedge clk);
      #1;
      model_step(r, f, o, p);
      chk("m_state", {6'd0, state}, 8'(m_state));
      chk("m_start", {7'd0, start}, {7'd0, m_state == 1});
      chk("m_tick", {7'd0, frame_tick}, {7'd0, m_ft});
      chk("m_pulse", {7'd0, flap_pulse}, {7'd0, m_fp});
      chk("m_score", score, bcd(m_score));
      chk("m_hiscore", hiscore, bcd(m_hi));
   endtask

   typedef struct {
      bit         r, f, o, p;
      logic [1:0] st;
      bit         sta;
      bit         fp;
      logic [7:0] sc;
      logic [7:0] hi;
   } vec_t;

   vec_t tbl[12];

   initial begin
      int nft;
      int last;
      bit ok;

      tbl[0]  = '{1, 1, 0, 0, 2'd0, 0, 0, 8'h00, 8'h00};
      tbl[1]  = '{1, 1, 0, 0, 2'd0, 0, 0, 8'h00, 8'h00};
      tbl[2]  = '{0, 0, 0, 0, 2'd0, 0, 0, 8'h00, 8'h00};
      tbl[3]  = '{0, 1, 0, 0, 2'd1, 1, 0, 8'h00, 8'h00};
      tbl[4]  = '{0, 1, 0, 0, 2'd1, 1, 0, 8'h00, 8'h00};
      tbl[5]  = '{0, 0, 0, 1, 2'd1, 1, 0, 8'h01, 8'h00};
      tbl[6]  = '{0, 1, 0, 1, 2'd1, 1, 1, 8'h02, 8'h00};
      tbl[7]  = '{0, 0, 0, 1, 2'd1, 1, 0, 8'h03, 8'h00};
      tbl[8]  = '{0, 0, 0, 1, 2'd1, 1, 0, 8'h04, 8'h00};
      tbl[9]  = '{0, 0, 0, 1, 2'd1, 1, 0, 8'h05, 8'h00};
      tbl[10] = '{0, 0, 1, 1, 2'd2, 0, 0, 8'h05, 8'h05};
      tbl[11] = '{0, 0, 0, 1, 2'd2, 0, 0, 8'h05, 8'h05};

      for (int i = 0; i < 12; i++) begin
         step(tbl[i].r, tbl[i].f, tbl[i].o, tbl[i].p);
         chk("tbl_state", {6'd0, state}, {6'd0, tbl[i].st});
         chk("tbl_start", {7'd0, start}, {7'd0, tbl[i].sta});
         chk("tbl_pulse", {7'd0, flap_pulse}, {7'd0, tbl[i].fp});
         chk("tbl_score", score, tbl[i].sc);
         chk("tbl_hiscore", hiscore, HI_EN ? tbl[i].hi : 8'h00);
      end

      // hold window: flap edges ignored until two ticks have elapsed
      nft = 0;
      for (int k = 0; k < 40 && nft < 2; k++) begin
         step(0, k[0], 0, 0);
         chk("hold_stay", {6'd0, state}, 8'd2);
         if (frame_tick) nft++;
      end
      chk("hold_ticks", 8'(nft), 8'd2);
      step(0, 0, 0, 0);
      chk("hold_last", {6'd0, state}, 8'd2);
      step(0, 1, 0, 0);
      chk("hold_exit", {6'd0, state}, 8'd0);
      step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      chk("restart_state", {6'd0, state}, 8'd1);
      chk("restart_score", score, 8'h00);
      chk("restart_hi", hiscore, HI_EN ? 8'h05 : 8'h00);

      // lower second game keeps the old best
      step(0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
      step(0, 0, 1, 0);
      chk("game2_state", {6'd0, state}, 8'd2);
      chk("game2_score", score, 8'h03);
      chk("game2_hi", hiscore, HI_EN ? 8'h05 : 8'h00);

      // back to PLAY, reach 07, then reset mid-game
      ok = 0;
      for (int k = 0; k < 60 && !ok; k++) begin
         step(0, k[0], 0, 0);
         if (state == 2'd0) ok = 1;
      end
      chk("to_idle", {7'd0, ok}, 8'd1);
      step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      for (int i = 0; i < 7; i++) step(0, 0, 0, 1);
      chk("mid_score", score, 8'h07);
      step(1, 0, 0, 0);
      chk("rst_state", {6'd0, state}, 8'd0);
      chk("rst_start", {7'd0, start}, 8'd0);
      chk("rst_score", score, 8'h00);
      chk("rst_hi", hiscore, 8'h00);

      // scoring carry and saturation
      step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
      chk("carry_10", score, 8'h10);
      for (int i = 0; i < 89; i++) step(0, 0, 0, 1);
      chk("reach_99", score, 8'h99);
      step(0, 0, 0, 1);
      chk("sat_99", score, 8'h99);
      step(0, 0, 1, 0);
      chk("sat_hi", hiscore, HI_EN ? 8'h99 : 8'h00);

      // 12 free-running cycles give 3 ticks, 4 apart
      nft = 0;
      last = -1;
      for (int k = 0; k < 12; k++) begin
         step(0, 0, 0, 0);
         if (frame_tick) begin
            if (last >= 0) chk("tick_gap", 8'(k - last), 8'd4);
            last = k;
            nft++;
         end
      end
      chk("tick_count", 8'(nft), 8'd3);

      // randomized run against the model
      step(1, 0, 0, 0);
      for (int k = 0; k < 4000; k++) begin
         step($urandom_range(0, 599) == 0,
              $urandom_range(0, 2) == 0,
              $urandom_range(0, 59) == 0,
              $urandom_range(0, 2) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
